// File: rtl/sdram_pkg.sv
// Shared command encodings, mode-word fields, error bit indices and bank state
// for the SDRAM device responder.
package sdram_pkg;

    // {ncs, nras, ncas, nwe}; any word with ncs=1 matches none of these (INHIBIT)
    localparam logic [3:0] CMD_NOP        = 4'b0111;
    localparam logic [3:0] CMD_BURST_TERM = 4'b0110;
    localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [3:0] CMD_READ       = 4'b0101;
    localparam logic [3:0] CMD_WRITE      = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
    localparam logic [3:0] CMD_REFRESH    = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE  = 4'b0000;

    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BL_MSB = 2;
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_CL_MSB = 6;
    localparam int MODE_OP_LSB = 7;
    localparam int MODE_OP_MSB = 8;
    localparam int A_AUTO_PRE  = 10;

    localparam logic [2:0] CL_2 = 3'd2;
    localparam logic [2:0] CL_3 = 3'd3;

    localparam int ERR_BANK = 0;
    localparam int ERR_TRCD = 1;
    localparam int ERR_MODE = 2;
    localparam int ERR_OPEN = 3;

    typedef enum logic {
        BANK_IDLE,
        BANK_ACTIVE
    } bank_state_e;

    function automatic logic mode_supported(input logic [11:0] m);
        return (m[MODE_BL_MSB:MODE_BL_LSB] == 3'b000) &&
               ((m[MODE_CL_MSB:MODE_CL_LSB] == CL_2) || (m[MODE_CL_MSB:MODE_CL_LSB] == CL_3)) &&
               (m[MODE_OP_MSB:MODE_OP_LSB] == 2'b00);
    endfunction

endpackage

// File: rtl/sdram_bank_fsm.sv
// One SDRAM bank: open/closed state, latched row and ACTIVE-to-access timer.
//
// state       | meaning
// ------------+-----------------------------------------------
// BANK_IDLE   | bank precharged, no row open
// BANK_ACTIVE | row latched in row_q; tRCD timer counting to 0
module sdram_bank_fsm
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int TRCD     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                act,
    input  logic                pre,
    input  logic                close_after,
    input  logic [ROW_BITS-1:0] row_in,
    output logic                active,
    output logic                trcd_busy,
    output logic [ROW_BITS-1:0] row
);

    localparam int CNT_W = (TRCD > 1) ? $clog2(TRCD) : 1;
    localparam logic [CNT_W-1:0] TRCD_LOAD = CNT_W'(TRCD - 1);

    bank_state_e         state_q, state_d;
    logic [ROW_BITS-1:0] row_q;
    logic [CNT_W-1:0]    cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BANK_IDLE:   if (act) state_d = BANK_ACTIVE;
            BANK_ACTIVE: if (pre || close_after) state_d = BANK_IDLE;
            default:     state_d = BANK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BANK_IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // A second ACTIVE on an open bank leaves row and timer untouched
            if (act && state_q == BANK_IDLE) begin
                row_q <= row_in;
                cnt_q <= TRCD_LOAD;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign active    = (state_q == BANK_ACTIVE);
    assign trcd_busy = (cnt_q != '0);
    assign row       = row_q;

endmodule

// File: rtl/sdram_responder.sv
// Chip-side SDRAM model: command decode, per-bank state, storage array,
// CAS-latency read pipeline and sticky protocol-violation flags.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 8,
    parameter int TRCD     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_ncs,
    input  logic        sd_nras,
    input  logic        sd_ncas,
    input  logic        sd_nwe,
    input  logic [11:0] sd_a,
    input  logic [1:0]  sd_ba,
    input  logic        sd_dqml,
    input  logic        sd_dqmh,
    input  logic [15:0] sd_dq_in,
    output logic [15:0] sd_dq_out,
    output logic        sd_dq_oe,
    output logic [11:0] mode_reg,
    output logic        mode_valid,
    output logic [15:0] refresh_count,
    output logic [3:0]  err
);

    localparam int ADDR_W = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [3:0]          cmd;
    logic                is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
    logic                acc_ok, rd_ok, wr_ok, cl3;
    logic [3:0]          bank_active, trcd_busy, act_b, pre_b, close_b;
    logic [ROW_BITS-1:0] bank_row [4];
    logic [ADDR_W-1:0]   addr;
    logic [15:0]         mem [DEPTH];
    logic [15:0]         rd_data;
    logic [3:0]          err_set;
    logic                pa_valid, pb_valid;
    logic [15:0]         pa_data, pb_data;

    assign cmd = {sd_ncs, sd_nras, sd_ncas, sd_nwe};

    always_comb begin
        is_act  = (cmd == CMD_ACTIVE);
        is_rd   = (cmd == CMD_READ);
        is_wr   = (cmd == CMD_WRITE);
        is_pre  = (cmd == CMD_PRECHARGE);
        is_ref  = (cmd == CMD_REFRESH);
        is_lmr  = (cmd == CMD_LOAD_MODE);
        acc_ok  = (is_rd || is_wr) && mode_valid && bank_active[sd_ba];
        rd_ok   = acc_ok && is_rd;
        wr_ok   = acc_ok && is_wr;
        cl3     = (mode_reg[MODE_CL_MSB:MODE_CL_LSB] == CL_3);
        addr    = {sd_ba, bank_row[sd_ba], sd_a[COL_BITS-1:0]};
        rd_data = mem[addr];

        err_set           = '0;
        err_set[ERR_BANK] = (is_act && bank_active[sd_ba]) || ((is_rd || is_wr) && !acc_ok);
        err_set[ERR_TRCD] = acc_ok && trcd_busy[sd_ba];
        err_set[ERR_MODE] = is_lmr && !mode_supported(sd_a);
        err_set[ERR_OPEN] = (is_ref || is_lmr) && (|bank_active);

        act_b   = '0;
        pre_b   = '0;
        close_b = '0;
        for (int i = 0; i < 4; i++) begin
            act_b[i]   = is_act && (sd_ba == 2'(i));
            pre_b[i]   = is_pre && (sd_a[A_AUTO_PRE] || (sd_ba == 2'(i)));
            close_b[i] = acc_ok && sd_a[A_AUTO_PRE] && (sd_ba == 2'(i));
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        sdram_bank_fsm #(
            .ROW_BITS(ROW_BITS),
            .TRCD    (TRCD)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .act        (act_b[b]),
            .pre        (pre_b[b]),
            .close_after(close_b[b]),
            .row_in     (sd_a[ROW_BITS-1:0]),
            .active     (bank_active[b]),
            .trcd_busy  (trcd_busy[b]),
            .row        (bank_row[b])
        );
    end

    // Array is deliberately not reset
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            if (!sd_dqml) mem[addr][7:0]  <= sd_dq_in[7:0];
            if (!sd_dqmh) mem[addr][15:8] <= sd_dq_in[15:8];
        end
    end

    // CL3 reads enter stage b, CL2 reads enter stage a; the output register is the last stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_reg      <= '0;
            mode_valid    <= 1'b0;
            refresh_count <= '0;
            err           <= '0;
            pa_valid      <= 1'b0;
            pa_data       <= '0;
            pb_valid      <= 1'b0;
            pb_data       <= '0;
            sd_dq_oe      <= 1'b0;
            sd_dq_out     <= '0;
        end else begin
            err <= err | err_set;
            if (is_lmr) begin
                mode_reg   <= sd_a;
                mode_valid <= 1'b1;
            end
            if (is_ref) refresh_count <= refresh_count + 16'd1;

            pb_valid <= rd_ok && cl3;
            pb_data  <= rd_data;
            if (rd_ok && !cl3) begin
                pa_valid <= 1'b1;
                pa_data  <= rd_data;
            end else begin
                pa_valid <= pb_valid;
                pa_data  <= pb_data;
            end
            sd_dq_oe  <= pa_valid;
            sd_dq_out <= pa_valid ? pa_data : 16'h0000;
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: mode load, round trips at CL2/CL3, byte
// masks, bank rules, timing violations, reset flush and auto-precharge.
module tb_sdram_responder;
    import sdram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sd_ncs, sd_nras, sd_ncas, sd_nwe;
    logic [11:0] sd_a;
    logic [1:0]  sd_ba;
    logic        sd_dqml, sd_dqmh;
    logic [15:0] sd_dq_in;
    logic [15:0] sd_dq_out;
    logic        sd_dq_oe;
    logic [11:0] mode_reg;
    logic        mode_valid;
    logic [15:0] refresh_count;
    logic [3:0]  err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdram_responder #(.ROW_BITS(4), .COL_BITS(8), .TRCD(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sd_ncs       (sd_ncs),
        .sd_nras      (sd_nras),
        .sd_ncas      (sd_ncas),
        .sd_nwe       (sd_nwe),
        .sd_a         (sd_a),
        .sd_ba        (sd_ba),
        .sd_dqml      (sd_dqml),
        .sd_dqmh      (sd_dqmh),
        .sd_dq_in     (sd_dq_in),
        .sd_dq_out    (sd_dq_out),
        .sd_dq_oe     (sd_dq_oe),
        .mode_reg     (mode_reg),
        .mode_valid   (mode_valid),
        .refresh_count(refresh_count),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One command per rising edge; returns 1ns after that edge
    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [11:0] a,
                         input logic [15:0] dq, input logic dqml, input logic dqmh);
        @(negedge clk);
        {sd_ncs, sd_nras, sd_ncas, sd_nwe} = c;
        sd_ba    = ba;
        sd_a     = a;
        sd_dq_in = dq;
        sd_dqml  = dqml;
        sd_dqmh  = dqmh;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        issue(CMD_NOP, 2'd0, 12'h000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {sd_ncs, sd_nras, sd_ncas, sd_nwe} = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [1:0] ba, input logic [7:0] col, input logic [15:0] d,
                      input logic dqml, input logic dqmh);
        issue(CMD_WRITE, ba, {4'h0, col}, d, dqml, dqmh);
    endtask

    // READ then walk the latency window: oe only on the CL-1 cycle afterwards
    task automatic rd_chk(input string tag, input logic [1:0] ba, input logic [7:0] col,
                          input logic a10, input logic [15:0] exp, input int cl);
        issue(CMD_READ, ba, {1'b0, a10, 2'b00, col}, 16'h0000, 1'b0, 1'b0);
        for (int k = 1; k <= cl; k++) begin
            nop();
            if (k == cl - 1) begin
                check({tag, " oe"}, 32'(sd_dq_oe), 32'd1);
                check({tag, " data"}, 32'(sd_dq_out), 32'(exp));
            end else begin
                check({tag, " oe idle"}, 32'(sd_dq_oe), 32'd0);
            end
        end
    endtask

    task automatic rd_dropped(input string tag, input logic [1:0] ba, input logic [7:0] col);
        issue(CMD_READ, ba, {4'h0, col}, 16'h0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            nop();
            check({tag, " no oe"}, 32'(sd_dq_oe), 32'd0);
        end
    endtask

    logic [11:0] bad_modes [4];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        {sd_ncs, sd_nras, sd_ncas, sd_nwe} = 4'b1111;
        sd_a     = '0;
        sd_ba    = '0;
        sd_dqml  = 1'b0;
        sd_dqmh  = 1'b0;
        sd_dq_in = '0;
        do_reset();

        check("rst oe", 32'(sd_dq_oe), 32'd0);
        check("rst dq_out", 32'(sd_dq_out), 32'd0);
        check("rst mode_reg", 32'(mode_reg), 32'd0);
        check("rst mode_valid", 32'(mode_valid), 32'd0);
        check("rst refresh", 32'(refresh_count), 32'd0);
        check("rst err", 32'(err), 32'd0);

        // Access before any LOAD_MODE is dropped
        issue(CMD_ACTIVE, 2'd0, 12'h000, 16'h0, 1'b0, 1'b0);
        nop();
        nop();
        rd_dropped("premode", 2'd0, 8'h00);
        check("premode err", 32'(err), 32'h1);

        do_reset();
        issue(CMD_LOAD_MODE, 2'd0, 12'h220, 16'h0, 1'b0, 1'b0);
        check("lmr valid", 32'(mode_valid), 32'd1);
        check("lmr reg", 32'(mode_reg), 32'h220);
        check("lmr err", 32'(err), 32'h0);

        // Round trip at CL2, access exactly TRCD after ACTIVE
        issue(CMD_ACTIVE, 2'd1, 12'h003, 16'h0, 1'b0, 1'b0);
        nop();
        wr(2'd1, 8'h12, 16'hA55A, 1'b0, 1'b0);
        rd_chk("rt cl2", 2'd1, 8'h12, 1'b0, 16'hA55A, 2);
        check("rt err", 32'(err), 32'h0);

        // Byte masks
        wr(2'd1, 8'h20, 16'hFFFF, 1'b0, 1'b0);
        wr(2'd1, 8'h20, 16'h1234, 1'b0, 1'b1);
        rd_chk("dqmh", 2'd1, 8'h20, 1'b0, 16'hFF34, 2);
        wr(2'd1, 8'h20, 16'hABCD, 1'b1, 1'b0);
        rd_chk("dqml", 2'd1, 8'h20, 1'b0, 16'hAB34, 2);

        // Switch to CL3 with all banks closed; data survives precharge
        issue(CMD_PRECHARGE, 2'd0, 12'h400, 16'h0, 1'b0, 1'b0);
        issue(CMD_LOAD_MODE, 2'd0, 12'h230, 16'h0, 1'b0, 1'b0);
        check("cl3 mode_reg", 32'(mode_reg), 32'h230);
        check("cl3 err", 32'(err), 32'h0);
        issue(CMD_ACTIVE, 2'd1, 12'h003, 16'h0, 1'b0, 1'b0);
        nop();
        rd_chk("cl3 rd", 2'd1, 8'h20, 1'b0, 16'hAB34, 3);
        wr(2'd1, 8'h21, 16'h5A5A, 1'b0, 1'b0);
        rd_chk("wr->rd", 2'd1, 8'h21, 1'b0, 16'h5A5A, 3);

        // Back-to-back CL3 reads
        issue(CMD_READ, 2'd1, 12'h020, 16'h0, 1'b0, 1'b0);
        issue(CMD_READ, 2'd1, 12'h021, 16'h0, 1'b0, 1'b0);
        check("b2b oe0", 32'(sd_dq_oe), 32'd0);
        nop();
        check("b2b oe1", 32'(sd_dq_oe), 32'd1);
        check("b2b d1", 32'(sd_dq_out), 32'hAB34);
        nop();
        check("b2b oe2", 32'(sd_dq_oe), 32'd1);
        check("b2b d2", 32'(sd_dq_out), 32'h5A5A);
        nop();
        check("b2b oe3", 32'(sd_dq_oe), 32'd0);

        // Bank rules
        issue(CMD_PRECHARGE, 2'd0, 12'h400, 16'h0, 1'b0, 1'b0);
        repeat (3) issue(CMD_REFRESH, 2'd0, 12'h000, 16'h0, 1'b0, 1'b0);
        check("ref count3", 32'(refresh_count), 32'd3);
        check("ref err", 32'(err), 32'h0);
        issue(CMD_ACTIVE, 2'd2, 12'h001, 16'h0, 1'b0, 1'b0);
        issue(CMD_ACTIVE, 2'd3, 12'h001, 16'h0, 1'b0, 1'b0);
        issue(CMD_PRECHARGE, 2'd2, 12'h000, 16'h0, 1'b0, 1'b0);
        issue(CMD_REFRESH, 2'd0, 12'h000, 16'h0, 1'b0, 1'b0);
        check("ref open err3", 32'(err), 32'h8);
        check("ref count4", 32'(refresh_count), 32'd4);
        rd_dropped("idle bank", 2'd2, 8'h00);
        check("idle bank err", 32'(err), 32'h9);

        // tRCD violation: access still performed
        do_reset();
        issue(CMD_LOAD_MODE, 2'd0, 12'h220, 16'h0, 1'b0, 1'b0);
        issue(CMD_ACTIVE, 2'd0, 12'h005, 16'h0, 1'b0, 1'b0);
        wr(2'd0, 8'h40, 16'h1357, 1'b0, 1'b0);
        check("trcd err1", 32'(err), 32'h2);
        nop();
        rd_chk("trcd wr kept", 2'd0, 8'h40, 1'b0, 16'h1357, 2);
        check("trcd err stays", 32'(err), 32'h2);

        // Double ACTIVE keeps the original row
        do_reset();
        issue(CMD_LOAD_MODE, 2'd0, 12'h220, 16'h0, 1'b0, 1'b0);
        issue(CMD_ACTIVE, 2'd0, 12'h005, 16'h0, 1'b0, 1'b0);
        nop();
        issue(CMD_ACTIVE, 2'd0, 12'h006, 16'h0, 1'b0, 1'b0);
        check("dbl act err0", 32'(err), 32'h1);
        nop();
        rd_chk("dbl act row", 2'd0, 8'h40, 1'b0, 16'h1357, 2);

        // Reset one cycle after a READ flushes the pipeline
        do_reset();
        issue(CMD_LOAD_MODE, 2'd0, 12'h220, 16'h0, 1'b0, 1'b0);
        issue(CMD_ACTIVE, 2'd0, 12'h005, 16'h0, 1'b0, 1'b0);
        nop();
        issue(CMD_READ, 2'd0, 12'h040, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        {sd_ncs, sd_nras, sd_ncas, sd_nwe} = CMD_NOP;
        @(posedge clk);
        #1;
        check("midrd oe", 32'(sd_dq_oe), 32'd0);
        check("midrd err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nop();
        check("midrd oe after", 32'(sd_dq_oe), 32'd0);

        // Auto-precharge closes the bank after the access
        issue(CMD_LOAD_MODE, 2'd0, 12'h220, 16'h0, 1'b0, 1'b0);
        issue(CMD_ACTIVE, 2'd0, 12'h005, 16'h0, 1'b0, 1'b0);
        nop();
        rd_chk("autopre rd", 2'd0, 8'h40, 1'b1, 16'h1357, 2);
        check("autopre err0", 32'(err), 32'h0);
        rd_dropped("autopre closed", 2'd0, 8'h40);
        check("autopre err1", 32'(err), 32'h1);

        // Unsupported mode words
        bad_modes[0] = 12'h221;
        bad_modes[1] = 12'h210;
        bad_modes[2] = 12'h0A0;
        bad_modes[3] = 12'h240;
        for (int i = 0; i < 4; i++) begin
            do_reset();
            issue(CMD_LOAD_MODE, 2'd0, bad_modes[i], 16'h0, 1'b0, 1'b0);
            check("bad mode err2", 32'(err), 32'h4);
            check("bad mode reg", 32'(mode_reg), 32'(bad_modes[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Cycle-accurate, synthesizable SDRAM device responder that models the chip side of the 16-bit single-data-rate SDRAM interface driven by the team's SDRAM controller. It decodes commands on the controller's pins, tracks per-bank open rows, and stores write data in an internal array. It returns read data after the programmed CAS latency and flags protocol violations. It replaces the physical chip in simulation and FPGA loopback builds used to validate controller timing.

## Interface
- `ROW_BITS`, default 4: row address bits stored; upper row bits are ignored.
- `COL_BITS`, default 8: column bits stored, taken from A[7:0].
- `TRCD`, default 2: minimum cycles from ACTIVE to READ/WRITE on the same bank.

- `clk` in 1: device clock; all inputs are sampled on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `sd_ncs`, `sd_nras`, `sd_ncas`, `sd_nwe` in 1 each: command pins.
- `sd_a` in 12: multiplexed address.
- `sd_ba` in 2: bank select.
- `sd_dqml`, `sd_dqmh` in 1 each: write byte masks; 1 means the byte is masked.
- `sd_dq_in` in 16: data from the controller.
- `sd_dq_out` out 16: read data.
- `sd_dq_oe` out 1: high while `sd_dq_out` must be driven.
- `mode_reg` out 12: last loaded mode word.
- `mode_valid` out 1: LOAD_MODE has been seen since reset.
- `refresh_count` out 16: AUTO_REFRESH counter; wraps.
- `err` out 4: sticky violation flags.
  - bit0: bank-state violation.
  - bit1: tRCD violation.
  - bit2: unsupported mode.
  - bit3: refresh or LOAD_MODE issued with a bank open.

## Operation
- **Command decode.** A command is `{ncs,nras,ncas,nwe}` when `ncs=0`. `ncs=1` is INHIBIT.
  - 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE.
  - 0110 BURST_TERMINATE is accepted as a NOP.
- **Per-bank FSM.** States are IDLE and ACTIVE(row). The bank also keeps a tRCD counter.
  - ACTIVE on an IDLE bank: latch `sd_a[ROW_BITS-1:0]`, load the counter with TRCD-1, go to ACTIVE.
  - ACTIVE on an ACTIVE bank: set err0; the row is unchanged.
  - PRECHARGE: closes `sd_ba` if A10=0, or all banks if A10=1. Precharging an IDLE bank is legal.
  - READ or WRITE to an IDLE bank: set err0; the access is dropped.
  - READ or WRITE while the tRCD counter is nonzero: set err1; the access is still performed.
  - A10=1 on READ/WRITE: auto-precharge; the bank returns to IDLE after the access.
- **Addressing.** Word index = {ba, row, sd_a[COL_BITS-1:0]}, giving a depth of 2^(2+ROW_BITS+COL_BITS).
- **WRITE.** Stores `sd_dq_in` at the sampling edge. Each byte is written only if its DQM bit is 0.
- **READ.** Returns the stored word for the addressed location. Burst length is always 1.
- **LOAD_MODE.** Latches `sd_a` into `mode_reg` and sets `mode_valid`. Sets err2 if any of the following hold:
  - burst length (A[2:0]) is not 000;
  - CAS latency (A[6:4]) is not 2 or 3;
  - op mode (A[8:7]) is not 00.
- **Before the first LOAD_MODE:** any READ or WRITE sets err0 and is dropped.
- **AUTO_REFRESH and LOAD_MODE with any bank ACTIVE:** set err3. The command still executes.
- **AUTO_REFRESH** increments `refresh_count`.
- **Error flags** clear only on reset.
- **Reset values:**
  - `sd_dq_oe`=0, `sd_dq_out`=0;
  - `mode_reg`=0, `mode_valid`=0;
  - `refresh_count`=0, `err`=0;
  - all banks IDLE, read pipeline empty.
- **Array contents** are not reset.
- **Reset asserted mid-read:** the pipeline flushes and `sd_dq_oe` is 0 on the next cycle.

## Timing
- **Read latency.** A READ sampled at edge T gives `sd_dq_out`/`sd_dq_oe` registered at edge T+CL-1. Data is therefore valid for the controller's sample at edge T+CL. `sd_dq_oe` is held for exactly one cycle.
- **Read pipeline.** Three stages of {valid, data}; CL selects the output tap. A READ may be issued every cycle.
- **Write-then-read.** A WRITE at edge T followed by a READ of the same word at T+1 returns the new data.
- **Same-edge access.** READ and WRITE cannot occur on the same edge; only one command per edge exists.
- **tRCD counter.** Decrements each cycle down to 0.
  - A READ at T+TRCD after ACTIVE at T is legal.
  - A READ at T+TRCD-1 sets err1.
- **CL changes.** A CL change takes effect for READs issued after the LOAD_MODE edge.

## Structure
- **Package `sdram_pkg`:**
  - `CMD_*` 4-bit constants;
  - mode field positions and the legal CL values;
  - `ERR_*` bit indices;
  - bank-state enum.
- **Sub-module `sdram_bank_fsm`:** IDLE/ACTIVE state, open row and tRCD counter. Instantiated 4 times, indexed by bank.
- **Top level:** decode, array, read pipeline and status registers.

## Test plan
- **Mode load.** LOAD_MODE 0x220 -> `mode_valid`=1, `mode_reg`=0x220, `err`=0. LOAD_MODE 0x221 -> err2 set.
- **Write/read round trip, CL=2.** ACTIVE ba1 row 3 at T0; WRITE col 0x12 data 0xA55A at T2; READ col 0x12 at T3 -> `sd_dq_oe`=1 with 0xA55A for the sample at T5 only.
- **Byte masks.** WRITE 0xFFFF, then WRITE 0x1234 with DQMH=1 -> read returns 0xFF34. Repeat with CL=3 -> data one cycle later.
- **Timing violations.** ACTIVE then READ one cycle later with TRCD=2 -> err1. READ to an IDLE bank -> err0 and no `sd_dq_oe`.
- **Bank rules.** PRECHARGE with A10=1 closes all banks, then AUTO_REFRESH ×3 -> `refresh_count`=3, err3 clear. AUTO_REFRESH with a bank open -> err3.
- **Reset and auto-precharge.** Deassert `rst_n` one cycle after a READ -> `sd_dq_oe` stays 0 and `err`=0. READ with A10=1 -> the next READ without ACTIVE sets err0.
